read_cmd_arb: RTL and testbench

//   Per-hash-bank read-command arbiter/router feeding the data RAM read ports of the vector cache.

---
 rtl/read_cmd_arb.sv | 136 +++++++++++++
 tb/tb_read_cmd_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/read_cmd_arb.sv
// Per-hash-bank read-command arbiter: one round-robin winner per bank per cycle,
// routed by dest_ram_id into a registered command slot per RAM read port.
module read_cmd_arb #(
  parameter int NUM_HASH     = 4,
  parameter int NUM_SRC      = 5,
  parameter int RAM_PER_HASH = 2,
  parameter int PLD_W        = 64,
  parameter int DEST_LSB     = 0,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIM   = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_HASH*NUM_SRC-1:0]                  v_req_vld,
  output logic [NUM_HASH*NUM_SRC-1:0]                  v_req_rdy,
  input  logic [NUM_HASH*NUM_SRC-1:0][PLD_W-1:0]       v_req_pld,
  output logic [NUM_HASH*RAM_PER_HASH-1:0]             toram_rd_cmd_vld,
  input  logic [NUM_HASH*RAM_PER_HASH-1:0]             toram_rd_cmd_rdy,
  output logic [NUM_HASH*RAM_PER_HASH-1:0][PLD_W-1:0]  toram_rd_cmd_pld
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int RAM_W = $clog2(RAM_PER_HASH);
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam int EVICT = NUM_SRC - 1;

  for (genvar h = 0; h < NUM_HASH; h++) begin : g_bank
    logic [SRC_W-1:0]                     ptr;
    logic [CNT_W-1:0]                     starve_cnt;
    logic [RAM_PER_HASH-1:0]              slot_vld;
    logic [RAM_PER_HASH-1:0][PLD_W-1:0]   slot_pld;
    logic [RAM_PER_HASH-1:0]              slot_free;
    logic [NUM_SRC-1:0][RAM_W-1:0]        dest;
    logic [NUM_SRC-1:0]                   elig;
    logic [NUM_SRC-1:0]                   rdy_bank;
    logic                                 other_elig;
    logic                                 starve_hit;
    logic                                 gnt_vld;
    logic [SRC_W-1:0]                     gnt_idx;
    logic [RAM_W-1:0]                     gnt_dest;
    logic [PLD_W-1:0]                     gnt_pld;

    always_comb begin
      for (int r = 0; r < RAM_PER_HASH; r++) begin
        slot_free[r] = !slot_vld[r] || toram_rd_cmd_rdy[h*RAM_PER_HASH + r];
      end
    end

    // A request is only eligible when its own target slot can take a load,
    // so a stalled RAM port never blocks traffic to the bank's other ports.
    always_comb begin
      for (int s = 0; s < NUM_SRC; s++) begin
        dest[s] = v_req_pld[h*NUM_SRC + s][DEST_LSB +: RAM_W];
        elig[s] = v_req_vld[h*NUM_SRC + s] && slot_free[dest[s]];
      end
    end

    always_comb begin
      other_elig = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (s != EVICT && elig[s]) other_elig = 1'b1;
      end
      starve_hit = (PRIO_MODE != 0) && (starve_cnt == CNT_W'(STARVE_LIM));
    end

    // At the starvation limit evict is masked out of the search for one cycle.
    always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      if (PRIO_MODE != 0 && elig[EVICT] && !starve_hit) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(EVICT);
      end else begin
        for (int k = 0; k < NUM_SRC; k++) begin
          int idx;
          idx = int'(ptr) + k;
          if (idx >= NUM_SRC) idx = idx - NUM_SRC;
          if (!gnt_vld && elig[idx] && !(starve_hit && idx == EVICT)) begin
            gnt_vld = 1'b1;
            gnt_idx = SRC_W'(idx);
          end
        end
      end
    end

    always_comb begin
      gnt_dest = dest[gnt_idx];
      gnt_pld  = v_req_pld[h*NUM_SRC + int'(gnt_idx)];
      for (int s = 0; s < NUM_SRC; s++) begin
        rdy_bank[s] = !rst && gnt_vld && (gnt_idx == SRC_W'(s));
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr        <= '0;
        starve_cnt <= '0;
      end else begin
        if (gnt_vld) begin
          ptr <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
        end
        if (PRIO_MODE == 0) begin
          starve_cnt <= '0;
        end else if (gnt_vld && gnt_idx != SRC_W'(EVICT)) begin
          starve_cnt <= '0;
        end else if (gnt_vld && other_elig) begin
          if (starve_cnt != CNT_W'(STARVE_LIM)) starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
          starve_cnt <= '0;
        end
      end
    end

    // A load on a slot being accepted the same cycle replaces it, keeping vld high.
    always_ff @(posedge clk) begin
      if (rst) begin
        slot_vld <= '0;
        slot_pld <= '0;
      end else begin
        for (int r = 0; r < RAM_PER_HASH; r++) begin
          if (gnt_vld && gnt_dest == RAM_W'(r)) begin
            slot_vld[r] <= 1'b1;
            slot_pld[r] <= gnt_pld;
          end else if (toram_rd_cmd_rdy[h*RAM_PER_HASH + r]) begin
            slot_vld[r] <= 1'b0;
          end
        end
      end
    end

    assign v_req_rdy[h*NUM_SRC +: NUM_SRC]                = rdy_bank;
    assign toram_rd_cmd_vld[h*RAM_PER_HASH +: RAM_PER_HASH] = slot_vld;
    assign toram_rd_cmd_pld[h*RAM_PER_HASH +: RAM_PER_HASH] = slot_pld;
  end

endmodule

// File: tb/tb_read_cmd_arb.sv
// Directed bench for read_cmd_arb: one round-robin instance and one evict-priority
// instance share all inputs.
module tb_read_cmd_arb;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [19:0]           vld;
  logic [19:0][63:0]     pld;
  logic [7:0]            cmd_rdy;
  logic [19:0]           rdy_rr, rdy_pr;
  logic [7:0]            cvld_rr, cvld_pr;
  logic [7:0][63:0]      cpld_rr, cpld_pr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  read_cmd_arb #(.PRIO_MODE(0)) u_dut_rr (
    .clk(clk), .rst(rst),
    .v_req_vld(vld), .v_req_rdy(rdy_rr), .v_req_pld(pld),
    .toram_rd_cmd_vld(cvld_rr), .toram_rd_cmd_rdy(cmd_rdy), .toram_rd_cmd_pld(cpld_rr)
  );

  read_cmd_arb #(.PRIO_MODE(1), .STARVE_LIM(8)) u_dut_pr (
    .clk(clk), .rst(rst),
    .v_req_vld(vld), .v_req_rdy(rdy_pr), .v_req_pld(pld),
    .toram_rd_cmd_vld(cvld_pr), .toram_rd_cmd_rdy(cmd_rdy), .toram_rd_cmd_pld(cpld_pr)
  );

  // Leaves the caller at a falling edge with rst low and all state cleared.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vld = '0; pld = '0; cmd_rdy = '1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '1; pld = '0; cmd_rdy = '1;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (rdy_rr !== 20'h0 || rdy_pr !== 20'h0) begin
        errors++; $display("FAIL reset_rdy: got %h/%h expected 0", rdy_rr, rdy_pr);
      end
      checks++;
      if (cvld_rr !== 8'h0 || cvld_pr !== 8'h0) begin
        errors++; $display("FAIL reset_cmd_vld: got %h/%h expected 0", cvld_rr, cvld_pr);
      end
    end
    checks++;
    if (cpld_rr !== '0) begin
      errors++; $display("FAIL reset_cmd_pld: got %h expected 0", cpld_rr);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if (rdy_rr !== 20'h08421) begin
      errors++; $display("FAIL reset_first_grant_rr: got %h expected %h", rdy_rr, 20'h08421);
    end
    checks++;
    if (rdy_pr !== 20'h84210) begin
      errors++; $display("FAIL reset_first_grant_prio: got %h expected %h", rdy_pr, 20'h84210);
    end
    @(negedge clk); #1;
    checks++;
    if (cvld_rr !== 8'h55) begin
      errors++; $display("FAIL reset_first_load: got %h expected 55", cvld_rr);
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    for (int s = 0; s < 5; s++) begin
      vld[s] = 1'b1;
      pld[s] = 64'h100 * (s + 1);
    end
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (rdy_rr !== (20'h1 << (i % 5))) begin
        errors++; $display("FAIL rr_grant[%0d]: got %h expected %h", i, rdy_rr, 20'h1 << (i % 5));
      end
      if (i > 0) begin
        checks++;
        if (cvld_rr[0] !== 1'b1 || cpld_rr[0] !== 64'h100 * ((i - 1) % 5 + 1)) begin
          errors++; $display("FAIL rr_slot[%0d]: got vld %b pld %h expected 1 %h",
                             i, cvld_rr[0], cpld_rr[0], 64'h100 * ((i - 1) % 5 + 1));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_routing();
    logic [63:0] p;
    p = 64'hDEAD_BEEF_0000_1235;
    do_reset();
    vld[11] = 1'b1; pld[11] = p; #1;
    checks++;
    if (rdy_rr !== 20'h00800) begin
      errors++; $display("FAIL route_grant: got %h expected 00800", rdy_rr);
    end
    @(negedge clk);
    vld = '0; #1;
    checks++;
    if (cvld_rr[5] !== 1'b1 || cvld_rr[4] !== 1'b0) begin
      errors++; $display("FAIL route_vld: got %b%b expected 10", cvld_rr[5], cvld_rr[4]);
    end
    checks++;
    if (cpld_rr[5] !== p) begin
      errors++; $display("FAIL route_pld: got %h expected %h", cpld_rr[5], p);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] exp_rdy [6];
    exp_rdy = '{5'b00001, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    do_reset();
    cmd_rdy[2] = 1'b0;
    vld[5] = 1'b1; pld[5] = 64'hA0;
    vld[8] = 1'b1; pld[8] = 64'hB1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) vld[8] = 1'b0;
      if (c == 5) cmd_rdy[2] = 1'b1;
      #1;
      checks++;
      if (rdy_rr[9:5] !== exp_rdy[c]) begin
        errors++; $display("FAIL bp_grant[%0d]: got %b expected %b", c, rdy_rr[9:5], exp_rdy[c]);
      end
      if (c >= 1) begin
        checks++;
        if (cvld_rr[2] !== 1'b1 || cpld_rr[2] !== 64'hA0) begin
          errors++; $display("FAIL bp_hold[%0d]: got vld %b pld %h expected 1 a0", c, cvld_rr[2], cpld_rr[2]);
        end
      end
      if (c == 2) begin
        checks++;
        if (cvld_rr[3] !== 1'b1 || cpld_rr[3] !== 64'hB1) begin
          errors++; $display("FAIL bp_other_port: got vld %b pld %h expected 1 b1", cvld_rr[3], cpld_rr[3]);
        end
      end
      if (c == 3) begin
        checks++;
        if (cvld_rr[3] !== 1'b0) begin
          errors++; $display("FAIL bp_other_drain: got %b expected 0", cvld_rr[3]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_evict_prio();
    logic [4:0] exp;
    do_reset();
    vld[4] = 1'b1; vld[2] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      exp = ((i % 9) < 8) ? 5'b10000 : 5'b00100;
      #1;
      checks++;
      if (rdy_pr[4:0] !== exp) begin
        errors++; $display("FAIL evict_prio[%0d]: got %b expected %b", i, rdy_pr[4:0], exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    cmd_rdy = '0;
    for (int k = 0; k < 20; k++) begin
      vld[k] = 1'b1;
      pld[k] = 64'h1000 * k + 64'((k % 5) % 2);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (cvld_rr !== 8'hFF || cvld_pr !== 8'hFF) begin
      errors++; $display("FAIL midop_full: got %h/%h expected ff", cvld_rr, cvld_pr);
    end
    checks++;
    if (rdy_rr !== 20'h0) begin
      errors++; $display("FAIL midop_blocked: got %h expected 0", rdy_rr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if (cvld_rr !== 8'h0 || cvld_pr !== 8'h0) begin
      errors++; $display("FAIL midop_cleared: got %h/%h expected 0", cvld_rr, cvld_pr);
    end
    checks++;
    if (rdy_rr !== 20'h08421 || rdy_pr !== 20'h84210) begin
      errors++; $display("FAIL midop_ptr_restart: got %h/%h expected 08421/84210", rdy_rr, rdy_pr);
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_routing();
    test_backpressure();
    test_evict_prio();
    test_midop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
